// File: rtl/fp_abs_arb_pkg.sv
// Shared types and the fp32 absolute-value helper for the fp_abs_arbiter block.
// Clearing the sign bit is the whole operation; NaN payloads and Inf encodings pass through.
package fp_abs_arb_pkg;

  typedef logic [31:0] fp32_t;

  localparam int SIGN_BIT = 31;
  localparam int CNT_W    = 16;

  function automatic fp32_t fp_abs(input fp32_t x);
    fp32_t r;
    r           = x;
    r[SIGN_BIT] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fp_abs_arbiter_if.sv
// Request/result handshake bundle between NUM_REQ issuing lanes, the arbiter and its consumer.
// The master modport is the lane/consumer side; the slave modport is the arbiter.
interface fp_abs_arbiter_if
  import fp_abs_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  res_valid;
  fp32_t                 res_data;
  logic [ID_W-1:0]       res_id;
  logic                  res_ready;

  modport master (
    output req_valid,
    output req_data,
    output res_ready,
    input  req_ready,
    input  res_valid,
    input  res_data,
    input  res_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  res_ready,
    output req_ready,
    output res_valid,
    output res_data,
    output res_id
  );

endinterface

// File: rtl/fp_abs_pipe.sv
// LATENCY-stage valid/data/id shift pipe sharing one enable; the last stage drives the result port.
// Bubbles travel with the pipe and are never squeezed out.
module fp_abs_pipe
  import fp_abs_arb_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ID_W    = 2
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            en,
  input  logic            in_valid,
  input  fp32_t           in_data,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  output fp32_t           out_data,
  output logic [ID_W-1:0] out_id
);

  logic [LATENCY-1:0] vld;
  fp32_t              dat [LATENCY];
  logic [ID_W-1:0]    tag [LATENCY];

  always_ff @(posedge aclk) begin
    if (areset) begin
      vld <= '0;
      // NOTE: data and id stages are reset too, so the result port reads 0 after reset rather than X.
      for (int s = 0; s < LATENCY; s++) begin
        dat[s] <= '0;
        tag[s] <= '0;
      end
    end else if (en) begin
      vld[0] <= in_valid;
      dat[0] <= fp_abs(in_data);
      tag[0] <= in_id;
      for (int s = 1; s < LATENCY; s++) begin
        vld[s] <= vld[s-1];
        dat[s] <= dat[s-1];
        tag[s] <= tag[s-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];
  assign out_id    = tag[LATENCY-1];

endmodule

// File: rtl/fp_abs_arbiter.sv
// Round-robin arbiter sharing one pipelined fp32 abs unit among NUM_REQ lanes.
// Optional FP_ABS_ARB_STATS_EN adds saturating per-lane grant counters and a stall-cycle counter.
module fp_abs_arbiter
  import fp_abs_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  fp_abs_arbiter_if.slave          bus
`ifdef FP_ABS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0]         stall_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic                stall;
  logic                accept;
  logic                found;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W:0]       cand;
  logic [ID_W-1:0]     ptr;
  fp32_t               operand;
  logic                pipe_valid;
  fp32_t               pipe_data;
  logic [ID_W-1:0]     pipe_id;

  assign stall = pipe_valid && !bus.res_ready;

  // Search ptr, ptr+1, ... with wrap; cand carries one spare bit so the wrap works for any NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before the search so no path can infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (!areset && !stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, ptr} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(NUM_REQ)) begin
          cand = cand - (ID_W+1)'(NUM_REQ);
        end
        if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
          found                  = 1'b1;
          grant[cand[ID_W-1:0]]  = 1'b1;
          grant_idx              = cand[ID_W-1:0];
        end
      end
    end
  end

  assign accept        = |grant;
  assign operand       = bus.req_data[{grant_idx, 5'b0} +: 32];
  assign bus.req_ready = grant;

  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  fp_abs_pipe #(
    .LATENCY (LATENCY),
    .ID_W    (ID_W)
  ) u_pipe (
    .aclk      (aclk),
    .areset    (areset),
    .en        (!stall),
    .in_valid  (accept),
    .in_data   (operand),
    .in_id     (grant_idx),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .out_id    (pipe_id)
  );

  assign bus.res_valid = pipe_valid;
  assign bus.res_data  = pipe_data;
  assign bus.res_id    = pipe_id;

`ifdef FP_ABS_ARB_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && grant_cnt[CNT_W*i +: CNT_W] != '1) begin
          grant_cnt[CNT_W*i +: CNT_W] <= grant_cnt[CNT_W*i +: CNT_W] + 1'b1;
        end
      end
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_abs_arbiter.sv
// Self-checking bench for fp_abs_arbiter: a queue-based reference model predicts grants, results and stalls.
// Build with FP_ABS_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_fp_abs_arbiter;
  import fp_abs_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int LATENCY = 2;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  fp_abs_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef FP_ABS_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
  logic [15:0]           stall_cnt;
`endif

  fp_abs_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LATENCY (LATENCY)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus)
`ifdef FP_ABS_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: in-flight ops with the number of un-stalled edges they have seen.
  typedef struct { logic [31:0] data; int id; int age; } op_t;
  typedef struct { logic [31:0] data; int id; } res_t;
  op_t  pend[$];
  res_t seen[$];
  int   ptr_m   = 0;
  bit   known   = 1'b0;
  int   n_acc   = 0;
  int   gcnt_m [NUM_REQ];
  int   stall_m = 0;

  logic [NUM_REQ-1:0] last_ready;
  logic               last_rv;
  logic [31:0]        last_data;
  logic [ID_W-1:0]    last_id;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit                 exp_rv;
    bit                 exp_stall;
    int                 g;
    logic [NUM_REQ-1:0] exp_ready;
    logic [31:0]        acc_data;
    @(negedge aclk);
    exp_rv    = known && pend.size() > 0 && pend[0].age == LATENCY;
    exp_stall = exp_rv && !bus.res_ready;
    g         = (areset || exp_stall || !known) ? -1 : rr_pick(bus.req_valid, ptr_m);
    exp_ready = '0;
    acc_data  = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      acc_data     = bus.req_data[32*g +: 32];
    end
    last_ready = bus.req_ready;
    last_rv    = bus.res_valid;
    last_data  = bus.res_data;
    last_id    = bus.res_id;
    if (known || areset) begin
      total++;
      if (bus.req_ready !== exp_ready) begin
        bad++;
        $display("FAIL req_ready @%0t: got %b expected %b", $time, bus.req_ready, exp_ready);
      end
    end
    if (known) begin
      total++;
      if (bus.res_valid !== exp_rv) begin
        bad++;
        $display("FAIL res_valid @%0t: got %b expected %b", $time, bus.res_valid, exp_rv);
      end
      if (exp_rv) begin
        total++;
        if (bus.res_data !== pend[0].data || bus.res_id !== ID_W'(pend[0].id)) begin
          bad++;
          $display("FAIL result @%0t: got %h/id%0d expected %h/id%0d", $time,
                   bus.res_data, bus.res_id, pend[0].data, pend[0].id);
        end
      end
`ifdef FP_ABS_ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++) begin
        total++;
        if (grant_cnt[16*i +: 16] !== 16'(gcnt_m[i])) begin
          bad++;
          $display("FAIL grant_cnt[%0d] @%0t: got %0d expected %0d", i, $time,
                   grant_cnt[16*i +: 16], gcnt_m[i]);
        end
      end
      total++;
      if (stall_cnt !== 16'(stall_m)) begin
        bad++;
        $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, stall_m);
      end
`endif
    end
    if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      seen.push_back('{bus.res_data, int'(bus.res_id)});
    end
    @(posedge aclk);
    if (areset) begin
      pend.delete();
      ptr_m   = 0;
      known   = 1'b1;
      stall_m = 0;
      for (int i = 0; i < NUM_REQ; i++) gcnt_m[i] = 0;
    end else if (known) begin
      if (exp_stall) begin
        if (stall_m < 65535) stall_m++;
      end else begin
        if (exp_rv) void'(pend.pop_front());
        for (int i = 0; i < pend.size(); i++) pend[i].age = pend[i].age + 1;
        if (g >= 0) begin
          pend.push_back('{acc_data & 32'h7FFF_FFFF, g, 1});
          ptr_m = (g + 1) % NUM_REQ;
          if (gcnt_m[g] < 65535) gcnt_m[g]++;
          n_acc++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    areset        = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.res_ready = 1'b1;
    step();
    step();
    total++;
    if (last_ready !== '0) begin
      bad++;
      $display("FAIL reset_ready: got %b expected 0", last_ready);
    end
    areset        = 1'b0;
    bus.req_valid = '0;
    total++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== 32'h0 || bus.res_id !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h id=%0d expected 0/0/0",
               bus.res_valid, bus.res_data, bus.res_id);
    end
    step();
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid     = 4'b0001;
    bus.req_data[31:0] = 32'hC0F8A3D7;
    step();
    total++;
    if (last_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_grant: got %b expected 0001", last_ready);
    end
    bus.req_valid = '0;
    for (int i = 1; i < LATENCY; i++) step();
    total++;
    if (last_rv !== 1'b0) begin
      bad++;
      $display("FAIL single_early: got res_valid=%b expected 0", last_rv);
    end
    step();
    total++;
    if (last_rv !== 1'b1 || last_data !== 32'h40F8A3D7 || last_id !== '0) begin
      bad++;
      $display("FAIL single_result: got v=%b d=%h id=%0d expected 1/40f8a3d7/0",
               last_rv, last_data, last_id);
    end
    drain(2);
  endtask

  task automatic test_round_robin();
    do_reset();
    seen.delete();
    bus.req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      bus.req_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      total++;
      if (last_ready !== NUM_REQ'(1 << (k % NUM_REQ))) begin
        bad++;
        $display("FAIL rr_grant[%0d]: got %b expected port %0d", k, last_ready, k % NUM_REQ);
      end
    end
    drain(LATENCY + 2);
    total++;
    if (seen.size() != 12) begin
      bad++;
      $display("FAIL rr_count: got %0d expected 12", seen.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        total++;
        if (seen[k].id != k % NUM_REQ) begin
          bad++;
          $display("FAIL rr_res_id[%0d]: got %0d expected %0d", k, seen[k].id, k % NUM_REQ);
        end
      end
    end
  endtask

  task automatic test_stall();
    int          a0;
    bit          hit;
    logic [31:0] hold_d;
    logic [ID_W-1:0] hold_id;
    do_reset();
    seen.delete();
    a0            = n_acc;
    bus.req_valid = 4'b1010;
    bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.res_ready = 1'b0;
    hit           = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = (last_rv === 1'b1);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL stall_first_result: got none within 20 cycles expected one");
    end
    total++;
    if (last_ready !== '0 || last_id !== ID_W'(1)) begin
      bad++;
      $display("FAIL stall_start: got ready=%b id=%0d expected 0000/1", last_ready, last_id);
    end
    hold_d  = last_data;
    hold_id = last_id;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (last_ready !== '0 || last_rv !== 1'b1 || last_data !== hold_d || last_id !== hold_id) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got ready=%b v=%b d=%h id=%0d expected 0000/1/%h/%0d",
                 i, last_ready, last_rv, last_data, last_id, hold_d, hold_id);
      end
    end
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    drain(2 * LATENCY + 4);
    total++;
    if (seen.size() != n_acc - a0) begin
      bad++;
      $display("FAIL stall_count: got %0d results expected %0d", seen.size(), n_acc - a0);
    end
    for (int k = 0; k < seen.size(); k++) begin
      total++;
      if (seen[k].id != ((k % 2 == 0) ? 1 : 3)) begin
        bad++;
        $display("FAIL stall_order[%0d]: got id %0d expected %0d", k, seen[k].id, (k % 2 == 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] ops [3];
    logic [31:0] exp [3];
    ops[0] = 32'h8000_0000; exp[0] = 32'h0000_0000;
    ops[1] = 32'hFF80_0000; exp[1] = 32'h7F80_0000;
    ops[2] = 32'hFFC0_0001; exp[2] = 32'h7FC0_0001;
    seen.delete();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid       = 4'b0100;
      bus.req_data[95:64] = ops[i];
      step();
    end
    drain(LATENCY + 2);
    total++;
    if (seen.size() != 3) begin
      bad++;
      $display("FAIL special_count: got %0d expected 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (seen[i].data !== exp[i] || seen[i].id != 2) begin
          bad++;
          $display("FAIL special[%0d]: got %h/id%0d expected %h/id2", i, seen[i].data, seen[i].id, exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.res_ready = 1'b0;
    step();
    bus.req_valid = 4'b0100;
    step();
    seen.delete();
    bus.req_valid = '0;
    areset        = 1'b1;
    step();
    areset        = 1'b0;
    bus.res_ready = 1'b1;
    step();
    total++;
    if (last_rv !== 1'b0) begin
      bad++;
      $display("FAIL midreset_valid: got %b expected 0", last_rv);
    end
    drain(LATENCY + 2);
    total++;
    if (seen.size() != 0) begin
      bad++;
      $display("FAIL midreset_leak: got %0d results expected 0", seen.size());
    end
    bus.req_valid = '1;
    step();
    total++;
    if (last_ready !== 4'b0001) begin
      bad++;
      $display("FAIL midreset_ptr: got %b expected 0001", last_ready);
    end
    drain(LATENCY + 2);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      areset        = ($urandom_range(0, 99) == 0);
      bus.req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_data[32*i +: 32] = ($urandom_range(0, 7) == 0) ? {1'b1, 8'hFF, 23'($urandom)} : $urandom;
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    areset = 1'b0;
    drain(2 * LATENCY + 4);
  endtask

`ifdef FP_ABS_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      bus.req_data[95:64] = $urandom;
      step();
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    step();
    step();
    drain(LATENCY + 4);
    total++;
    if (grant_cnt !== {16'd0, 16'd5, 16'd0, 16'd0} || stall_cnt !== 16'd2) begin
      bad++;
      $display("FAIL stats: got grant_cnt=%h stall_cnt=%0d expected 0000000500000000/2",
               grant_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset        = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_special();
    test_reset_midflight();
    test_random();
`ifdef FP_ABS_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
